// File: rtl/sample_ring_writer.sv
// sample_ring_writer
//   Accepts 32-bit audio samples on a valid/ready stream and writes each one
//   as four little-endian byte writes to the byte-wide memory sizer, into a
//   circular buffer of 32-bit words starting at BASE_ADR. The last byte is held
//   for FLUSH_CYCLES cycles after its ack so the sizer can commit the word.
//   After those cycles, one select-low gap cycle lets the sizer go idle before
//   the next sample.
//
// Optional feature (macro SAMPLE_RING_DROP_ON_FULL_EN):
//   defined   - in_ready_o stays high in IDLE. A sample offered while the ring
//               is full is discarded and counted in drop_cnt_o (saturating).
//   undefined - a full ring backpressures via in_ready_o. drop_cnt_o is 0.
//
// Ports:
//   clk_i, reset_i         clock, asynchronous active-high reset
//   in_valid_i/in_ready_o  sample stream handshake, in_dat_i sample data
//   mem_sel_o, mem_we_o    sizer master select / write enable
//   mem_adr_o, mem_dat_o   byte address / write byte
//   mem_ack_i              sizer byte ack
//   rd_ptr_i               consumer word index
//   wr_ptr_o               next word index to be written
//   full_o                 ring full (one word always left free)
//   drop_cnt_o             dropped-sample count
//
// FLUSH_CYCLES is expected to be at least 1.

module sample_ring_writer #(
  parameter int unsigned          ADR_WIDTH    = 16,
  parameter logic [ADR_WIDTH-1:0] BASE_ADR     = '0,
  parameter int unsigned          RING_WORDS   = 256,
  parameter int unsigned          FLUSH_CYCLES = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [31:0]                   in_dat_i,
  output logic                          mem_sel_o,
  output logic                          mem_we_o,
  output logic [ADR_WIDTH-1:0]          mem_adr_o,
  output logic [7:0]                    mem_dat_o,
  input  logic                          mem_ack_i,
  input  logic [$clog2(RING_WORDS)-1:0] rd_ptr_i,
  output logic [$clog2(RING_WORDS)-1:0] wr_ptr_o,
  output logic                          full_o,
  output logic [7:0]                    drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(RING_WORDS);
  localparam int unsigned FC_W  = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    WR_BYTE = 4'b0010,
    FLUSH   = 4'b0100,
    GAP     = 4'b1000
  } state_e;

  state_e               state_q;
  logic [23:0]          sample_q;     // bytes 1..3 still to be written, byte 1 lowest
  logic [1:0]           idx_q;
  logic [FC_W-1:0]      flush_cnt_q;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     wr_ptr_d;
  logic                 sel_q;
  logic                 we_q;
  logic [ADR_WIDTH-1:0] adr_q;
  logic [7:0]           dat_q;
  logic                 idle;
  logic                 accept;
  logic                 start;

  // Ring wraps naturally because RING_WORDS is a power of two
  assign wr_ptr_d = wr_ptr_q + PTR_W'(1);
  assign full_o   = (wr_ptr_d == rd_ptr_i);
  assign idle     = (state_q == IDLE);
  assign accept   = in_valid_i & in_ready_o;

`ifdef SAMPLE_RING_DROP_ON_FULL_EN
  logic [7:0] drop_cnt_q;

  // Ready is gated by reset so it reads low while reset is held
  assign in_ready_o = idle & ~reset_i;
  assign start      = accept & ~full_o;
  assign drop_cnt_o = drop_cnt_q;

  // Saturating count of samples discarded against a full ring
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_cnt_q <= 8'h00;
    end else if (accept && full_o && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'h01;
    end
  end
`else
  assign in_ready_o = idle & ~full_o & ~reset_i;
  assign start      = accept;
  assign drop_cnt_o = 8'h00;
`endif

  assign wr_ptr_o  = wr_ptr_q;
  assign mem_sel_o = sel_q;
  assign mem_we_o  = we_q;
  assign mem_adr_o = adr_q;
  assign mem_dat_o = dat_q;

  // Sample serialiser FSM with registered bus outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      idx_q       <= '0;
      flush_cnt_q <= '0;
      wr_ptr_q    <= '0;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sample_q <= in_dat_i[31:8];
            idx_q    <= '0;
            sel_q    <= 1'b1;
            we_q     <= 1'b1;
            adr_q    <= BASE_ADR + ADR_WIDTH'({wr_ptr_q, 2'b00});
            dat_q    <= in_dat_i[7:0];
            state_q  <= WR_BYTE;
          end
        end
        WR_BYTE: begin
          if (mem_ack_i) begin
            if (idx_q == 2'd3) begin
              flush_cnt_q <= '0;
              state_q     <= FLUSH;
            end else begin
              idx_q    <= idx_q + 2'd1;
              adr_q    <= adr_q + ADR_WIDTH'(1);
              dat_q    <= sample_q[7:0];
              sample_q <= {8'h00, sample_q[23:8]};
            end
          end
        end
        FLUSH: begin
          // Byte 3 stays on the bus; acks here only re-write the same byte
          if (flush_cnt_q == FC_W'(FLUSH_CYCLES - 1)) begin
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            wr_ptr_q <= wr_ptr_d;
            state_q  <= GAP;
          end else begin
            flush_cnt_q <= flush_cnt_q + FC_W'(1);
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_ring_writer.sv
// tb_sample_ring_writer
//   Bench for sample_ring_writer with RING_WORDS=4, BASE_ADR=16'h0100 and
//   FLUSH_CYCLES=4. A transaction-level reference model tracks the accepted
//   sample, how many of its bytes the sizer has acked and how long byte 3 has
//   been held. Every cycle it predicts the bus, stream and pointer outputs.

module tb_sample_ring_writer;

  localparam int unsigned RW    = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned FLUSH = 4;
  localparam logic [15:0] BASE  = 16'h0100;
`ifdef SAMPLE_RING_DROP_ON_FULL_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [31:0]   in_dat_i;
  logic          mem_sel_o;
  logic          mem_we_o;
  logic [15:0]   mem_adr_o;
  logic [7:0]    mem_dat_o;
  logic          mem_ack_i;
  logic [PW-1:0] rd_ptr_i;
  logic [PW-1:0] wr_ptr_o;
  logic          full_o;
  logic [7:0]    drop_cnt_o;

  sample_ring_writer #(
    .ADR_WIDTH   (16),
    .BASE_ADR    (BASE),
    .RING_WORDS  (RW),
    .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_dat_i   (in_dat_i),
    .mem_sel_o  (mem_sel_o),
    .mem_we_o   (mem_we_o),
    .mem_adr_o  (mem_adr_o),
    .mem_dat_o  (mem_dat_o),
    .mem_ack_i  (mem_ack_i),
    .rd_ptr_i   (rd_ptr_i),
    .wr_ptr_o   (wr_ptr_o),
    .full_o     (full_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state
  int          wp_m;       // words committed so far, modulo RW
  int          drop_m;
  bit          busy_m;     // a sample is on the sizer bus
  bit          gap_m;      // the select-low cycle after a sample
  int          acked_m;    // bytes of the current sample acked (0..4)
  int          hold_m;     // cycles byte 3 has been held after its ack
  logic [31:0] cur_m;

  // Stimulus control
  bit hs_last;
  bit rdy_seen;
  int hs_cnt = 0;
  int ack_mode;            // 0: always ack, 1: ack after 3 wait cycles, 2: random
  int wcnt;
  bit consume_en;
  bit src_rand;
  int rdp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare outputs against the model, then advance the model across the coming edge
  task automatic monitor();
    bit full_exp;
    bit rdy_exp;
    int bsel;
    rdy_seen = in_ready_o;
    if (reset_i) begin
      hs_last = 1'b0;
      check("rst_ready", 32'(in_ready_o), 32'd0);
      check("rst_sel", 32'(mem_sel_o), 32'd0);
      check("rst_we", 32'(mem_we_o), 32'd0);
      check("rst_adr", 32'(mem_adr_o), 32'd0);
      check("rst_dat", 32'(mem_dat_o), 32'd0);
      check("rst_wr_ptr", 32'(wr_ptr_o), 32'd0);
      check("rst_drop", 32'(drop_cnt_o), 32'd0);
      wp_m = 0; drop_m = 0; busy_m = 0; gap_m = 0; acked_m = 0; hold_m = 0;
      return;
    end
    hs_last = in_valid_i && in_ready_o;
    if (hs_last) hs_cnt++;
    full_exp = (((wp_m + 1) % RW) == int'(rd_ptr_i));
    rdy_exp  = !busy_m && !gap_m && (DROP || !full_exp);
    check("wr_ptr", 32'(wr_ptr_o), 32'(wp_m));
    check("full", 32'(full_o), 32'(full_exp));
    check("ready", 32'(in_ready_o), 32'(rdy_exp));
    check("sel", 32'(mem_sel_o), 32'(busy_m));
    check("we", 32'(mem_we_o), 32'(busy_m));
    check("drop_cnt", 32'(drop_cnt_o), 32'(drop_m));
    if (busy_m) begin
      bsel = (acked_m < 4) ? acked_m : 3;
      check("adr", 32'(mem_adr_o), 32'(int'(BASE) + 4 * wp_m + bsel));
      check("dat", 32'(mem_dat_o), (cur_m >> (8 * bsel)) & 32'hFF);
    end
    if (gap_m) begin
      gap_m = 0;
    end else if (busy_m) begin
      if (acked_m < 4) begin
        if (mem_ack_i) acked_m++;
      end else begin
        hold_m++;
        if (hold_m == FLUSH) begin
          busy_m = 0;
          gap_m  = 1;
          wp_m   = (wp_m + 1) % RW;
        end
      end
    end else if (in_valid_i && rdy_exp) begin
      if (DROP && full_exp) begin
        if (drop_m < 255) drop_m++;
      end else begin
        busy_m = 1; acked_m = 0; hold_m = 0; cur_m = in_dat_i;
      end
    end
  endtask

  // Sizer ack responder, consumer pointer and random sample source
  task automatic drive();
    case (ack_mode)
      0: mem_ack_i = 1'b1;
      1: begin
        if (!mem_sel_o) begin
          wcnt = 0;
          mem_ack_i = 1'b0;
        end else begin
          mem_ack_i = (wcnt == 3);
          wcnt = mem_ack_i ? 0 : wcnt + 1;
        end
      end
      default: mem_ack_i = ($urandom_range(0, 99) < 60);
    endcase
    if (consume_en && (rdp != wp_m) && ($urandom_range(0, 3) == 0)) rdp = (rdp + 1) % RW;
    rd_ptr_i = PW'(rdp);
    if (src_rand && (hs_last || !in_valid_i)) begin
      in_valid_i = ($urandom_range(0, 2) != 0);
      in_dat_i   = $urandom();
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    monitor();
    cyc++;
    @(posedge clk_i);
    #1;
    drive();
  endtask

  task automatic wait_hs(input int max_cyc);
    int n = 0;
    do begin
      step();
      n++;
    end while (!hs_last && n < max_cyc);
    check("hs_seen", 32'(hs_last), 32'd1);
  endtask

  task automatic send(input logic [31:0] d);
    in_valid_i = 1'b1;
    in_dat_i   = d;
    wait_hs(40);
    in_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (2) step();
    reset_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    int hb;
    reset_i = 1'b1; in_valid_i = 1'b0; in_dat_i = '0; mem_ack_i = 1'b0;
    rd_ptr_i = '0; rdp = 0; ack_mode = 0; wcnt = 0; consume_en = 0; src_rand = 0;
    repeat (3) step();
    reset_i = 1'b0;

    // Single sample, ack tied high: 10-cycle sample period
    send(32'hA1B2C3D4);
    k = 0;
    do begin step(); k++; end while (!rdy_seen && k < 40);
    check("ready_again", 32'(k), 32'd10);
    check("t1_wr_ptr", 32'(wr_ptr_o), 32'd1);

    // Three wait cycles per byte: 1 + 4*4 + FLUSH + 1 cycles per sample
    ack_mode = 1;
    send($urandom());
    k = 0;
    do begin step(); k++; end while (!rdy_seen && k < 60);
    check("ws_ready_again", 32'(k), 32'd22);
    send($urandom());
    repeat (25) step();

    // Randomised traffic with random acks and a random consumer
    do_reset();
    ack_mode = 2; consume_en = 1; src_rand = 1;
    repeat (1500) step();
    src_rand = 0; consume_en = 0; in_valid_i = 1'b0;
    repeat (40) step();

    // Wrap from word 3 to word 0, then the ring is full
    rdp = 0; rd_ptr_i = '0; ack_mode = 0;
    do_reset();
    send($urandom());
    send($urandom());
    rdp = 1; rd_ptr_i = PW'(1);
    send($urandom());
    repeat (12) step();
    check("wrap_pre_ptr", 32'(wr_ptr_o), 32'd3);
    send(32'hCAFEF00D);
    check("wrap_adr0", 32'(mem_adr_o), 32'h010C);
    repeat (12) step();
    check("wrap_ptr", 32'(wr_ptr_o), 32'd0);
    check("wrap_full", 32'(full_o), 32'd1);
    check("wrap_ready", 32'(in_ready_o), 32'(DROP));

    // Full release: consumer advances by one, handshake on the next edge
    in_valid_i = 1'b1; in_dat_i = 32'h1234_5678;
    hb = hs_cnt;
    repeat (5) step();
    check("full_block", 32'(hs_cnt - hb), DROP ? 32'd5 : 32'd0);
    rdp = 2; rd_ptr_i = PW'(2);
    step();
    check("release_hs", 32'(hs_last), 32'd1);
    in_valid_i = 1'b0;
    repeat (12) step();

`ifdef SAMPLE_RING_DROP_ON_FULL_EN
    // Ring full again: 300 offered samples are all dropped
    check("drop_pre_full", 32'(full_o), 32'd1);
    in_valid_i = 1'b1;
    repeat (300) begin
      in_dat_i = $urandom();
      step();
    end
    in_valid_i = 1'b0;
    step();
    check("drop_sat", 32'(drop_cnt_o), 32'hFF);
`endif

    // Reset on byte 2 abandons the word; the next sample starts at byte 0
    rdp = 0; rd_ptr_i = '0;
    do_reset();
    send(32'h5566_7788);
    k = 0;
    while (mem_adr_o != BASE + 16'd2 && k < 10) begin step(); k++; end
    check("mid_byte2_adr", 32'(mem_adr_o), 32'(BASE + 16'd2));
    reset_i = 1'b1;
    #1;
    check("mid_rst_sel", 32'(mem_sel_o), 32'd0);
    check("mid_rst_we", 32'(mem_we_o), 32'd0);
    check("mid_rst_adr", 32'(mem_adr_o), 32'd0);
    check("mid_rst_dat", 32'(mem_dat_o), 32'd0);
    check("mid_rst_ptr", 32'(wr_ptr_o), 32'd0);
    check("mid_rst_ready", 32'(in_ready_o), 32'd0);
    step();
    step();
    reset_i = 1'b0;
    send(32'h0BAD_BEEF);
    check("post_rst_adr0", 32'(mem_adr_o), 32'(BASE));
    check("post_rst_dat0", 32'(mem_dat_o), 32'hEF);
    repeat (12) step();
    check("post_rst_ptr", 32'(wr_ptr_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sample_ring_writer.md
Name: sample_ring_writer

Overview:
- Upstream feeder for the byte-wide memory sizer in the S/PDIF capture path.
- Accepts 32-bit audio samples on a valid/ready stream.
- Serialises each sample into four byte writes on the sizer's 8-bit master port, into a circular buffer in 32-bit sample memory.
- Tracks the write pointer against a consumer read pointer for full detection.

Parameters:
ADR_WIDTH, 16, width of memory address bus
BASE_ADR, 16'h0000, byte address of ring start; must be 4-byte aligned
RING_WORDS, 256, ring depth in 32-bit words; power of two, at least 2
FLUSH_CYCLES, 4, cycles the last byte is held after its ack so the sizer can commit the word

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous reset, active-high
in_valid_i  in  1  sample valid
in_ready_o  out  1  sample accepted when valid and ready are both high at a rising edge
in_dat_i  in  32  sample data
mem_sel_o  out  1  sizer master select
mem_we_o  out  1  sizer write enable
mem_adr_o  out  ADR_WIDTH  byte address
mem_dat_o  out  8  write byte
mem_ack_i  in  1  sizer byte ack
rd_ptr_i  in  log2(RING_WORDS)  consumer word index
wr_ptr_o  out  log2(RING_WORDS)  next word index to be written
full_o  out  1  ring full
drop_cnt_o  out  8  dropped-sample count (see Optional Feature)

Behaviour:
- Reset (asynchronous, immediate) drives all outputs low/zero: in_ready_o, mem_sel_o, mem_we_o, mem_adr_o, mem_dat_o, wr_ptr_o, drop_cnt_o. The FSM returns to IDLE and the sample register clears.
- full_o is combinational: ((wr_ptr_o + 1) mod RING_WORDS) == rd_ptr_i. One word is always left free. Empty is wr_ptr_o == rd_ptr_i; this is consumer-side and has no output here.
- FSM states, one-hot: IDLE, WR_BYTE, FLUSH, GAP.
- IDLE:
  - in_ready_o = ~full_o.
  - On handshake, latch in_dat_i, set byte index to 0, go to WR_BYTE.
  - mem_sel_o is low in IDLE.
- WR_BYTE:
  - Drive mem_sel_o = 1, mem_we_o = 1.
  - mem_adr_o = BASE_ADR + 4*wr_ptr_o + idx.
  - mem_dat_o = sample byte idx, little-endian: idx 0 carries bits [7:0] at the lowest address.
  - When mem_ack_i is high at an edge:
    - idx < 3: increment idx; the next address appears the following cycle.
    - idx == 3: go to FLUSH.
  - With no ack, outputs hold indefinitely. There is no timeout.
- FLUSH:
  - sel, we, address and data of byte 3 are held unchanged for exactly FLUSH_CYCLES cycles.
  - Any mem_ack_i seen here is ignored; re-writing byte 3 is idempotent.
  - On exit, wr_ptr_o increments modulo RING_WORDS (wraps from RING_WORDS-1 to 0), then go to GAP.
- GAP:
  - One cycle with mem_sel_o = 0 so the sizer returns to its idle state, then go to IDLE.
- Throughput, no wait states: 1 (accept) + 4 + FLUSH_CYCLES + 1 cycles per sample. With defaults this is 10 cycles.
- in_ready_o is low in every state except IDLE.
- rd_ptr_i changing mid-sample has no effect on the word in flight. full_o is re-evaluated in IDLE only, for the acceptance decision.
- Reset asserted mid-sample abandons the partial word. Bytes already written stay in memory; wr_ptr_o does not advance.

Optional Feature:
Macro: SAMPLE_RING_DROP_ON_FULL_EN
- Defined:
  - in_ready_o = 1 in IDLE regardless of full_o.
  - A sample accepted while full_o = 1 is discarded. No memory access occurs, the FSM stays in IDLE, and drop_cnt_o increments, saturating at 8'hFF.
  - drop_cnt_o clears only on reset.
- Undefined:
  - Full ring backpressures via in_ready_o = 0.
  - drop_cnt_o is tied to 0.

Test Plan:
- Single sample 32'hA1B2C3D4 to empty ring, BASE_ADR 16'h0100, mem_ack_i tied high:
  - Byte writes D4@0100, C3@0101, B2@0102, A1@0103.
  - Byte 3 held 4 cycles, then one GAP cycle.
  - wr_ptr_o = 1; in_ready_o high again 10 cycles after the handshake.
- Wait states: ack delayed 3 cycles per byte -> address and data stable while unacked; no byte skipped or duplicated; idx advances only on ack.
- Wrap, RING_WORDS = 4: start wr_ptr = 3, rd_ptr_i = 1 -> write lands at BASE+12..15 and wr_ptr_o = 0. Next: full_o = 1 and in_ready_o = 0 (macro undefined).
- Full release: ring full, in_valid_i held high; set rd_ptr_i to advance by 1 -> handshake the next cycle.
- Reset asserted on byte 2 of a sample -> all outputs 0 immediately; wr_ptr_o unchanged from before the sample; next sample starts at idx 0.
- With SAMPLE_RING_DROP_ON_FULL_EN, full ring, 300 samples offered -> no mem_sel_o activity; drop_cnt_o = 8'hFF; in_ready_o stays high.
